mem_rmst: RTL

Memory read master for the convolution accelerator's simulation memory subsystem. On a `go` command it fetches `length` bytes from word-addressed memory as 128-bit beats, starting at `base`, and buffers the returned data in an internal show-ahead FIFO. The compute side drains the FIFO through a read-buffer handshake. Credit-based issue control guarantees the FIFO never overflows.

---
 rtl/mem_rmst.sv | 115 +++++++++++
 1 files changed

// File: rtl/mem_rmst.sv
// Memory read master: fetches 128-bit beats into a show-ahead FIFO, using credits so
// the number of beats in the FIFO or still outstanding never exceeds the FIFO depth.
module mem_rmst #(
  parameter int FIFO_DEPTH = 256,
  parameter int FIFO_AW    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         read_control_fixed_location,
  input  logic [31:0]  read_control_read_base,
  input  logic [31:0]  read_control_read_length,
  input  logic         read_control_go,
  output logic         read_control_done,
  input  logic         read_user_read_buffer,
  output logic [127:0] read_user_buffer_output_data,
  output logic         read_user_data_available,
  output logic         rreq,
  input  logic         rrdy,
  output logic         rena,
  output logic [31:0]  raddr,
  input  logic         rvalid,
  input  logic [127:0] rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam logic [FIFO_AW+1:0] DEPTH_W = (FIFO_AW+2)'(FIFO_DEPTH);

  state_t             state, state_next;
  logic [27:0]        remaining;
  logic [FIFO_AW:0]   inflight, inflight_next;
  logic [FIFO_AW:0]   used;
  logic [31:0]        addr;
  logic               fixed;
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [127:0]       mem [FIFO_DEPTH];
  logic [FIFO_AW+1:0] credit;
  logic               start, push, pop;
  logic               unused_low;

  assign unused_low = ^{read_control_read_base[3:0], read_control_read_length[3:0]};

  assign start  = (state == IDLE) && read_control_go && (read_control_read_length[31:4] != 28'd0);
  assign push   = rvalid && (inflight != '0);
  assign pop    = read_user_read_buffer && (used != '0);
  assign credit = {1'b0, used} + {1'b0, inflight};

  assign inflight_next = inflight + {{FIFO_AW{1'b0}}, rena} - {{FIFO_AW{1'b0}}, push};

  assign raddr                        = addr;
  assign read_user_data_available     = (used != '0);
  assign read_user_buffer_output_data = mem[rd_ptr];

  // Issue is only allowed while the FIFO plus outstanding beats leaves room for one more.
  always_comb begin
    state_next        = state;
    rena              = 1'b0;
    rreq              = 1'b0;
    read_control_done = 1'b0;
    case (state)
      IDLE: begin
        read_control_done = 1'b1;
        if (start) state_next = ISSUE;
      end
      ISSUE: begin
        rreq = 1'b1;
        rena = rrdy && (remaining != 28'd0) && (credit < DEPTH_W);
        if (rena && (remaining == 28'd1)) state_next = DRAIN;
      end
      DRAIN: begin
        if (inflight_next == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      inflight  <= '0;
      addr      <= '0;
      fixed     <= 1'b0;
    end else begin
      state    <= state_next;
      inflight <= inflight_next;
      if (start) begin
        remaining <= read_control_read_length[31:4];
        addr      <= {4'd0, read_control_read_base[31:4]};
        fixed     <= read_control_fixed_location;
      end else if (rena) begin
        remaining <= remaining - 28'd1;
        if (!fixed) addr <= addr + 32'd1;
      end
    end
  end

  // Show-ahead FIFO; a push into an empty FIFO becomes visible on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= rdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      used <= used + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
    end
  end

endmodule
